fetch_sequencer: RTL and testbench

Sequencer for the instruction-fetch stage. It owns the fetch PC and issues fetch requests to an instruction memory over a valid/ready request channel with a response channel. It delivers fetched instructions to decode through a registered IF/ID output with valid, stall and flush control. It handles execute-stage redirects (taken branches and jumps) by flushing the IF/ID output and discarding any stale in-flight response.

---
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one outstanding imem request at a time,
// and delivers instructions to decode through a registered IF/ID stage backed by a one-entry skid.
module fetch_sequencer #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            ImemReqValid,
  output logic [XLEN-1:0] ImemReqAddr,
  input  logic            ImemReqReady,
  input  logic            ImemRspValid,
  input  logic [31:0]     ImemRspData,
  output logic            InstrValidD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            skid_vld, skid_vld_n;
  logic [31:0]     skid_instr, skid_instr_n;
  logic [XLEN-1:0] skid_pc, skid_pc_n;
  logic            vld_n;
  logic [31:0]     instr_n;
  logic [XLEN-1:0] pcd_n, pc4_n;

  logic            out_free;
  logic            req_fire;
  logic [XLEN-1:0] target;

  // Request side is decoded only from registered state, never from ImemReqReady.
  assign ImemReqValid = (state == S_REQ) && !skid_vld;
  assign ImemReqAddr  = pc;

  assign out_free = !InstrValidD || !StallD;
  assign req_fire = ImemReqValid && ImemReqReady;
  assign target   = PCTargetE & ALIGN_MASK;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    skid_vld_n   = skid_vld;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    vld_n        = InstrValidD;
    instr_n      = InstrD;
    pcd_n        = PCD;
    pc4_n        = PCPlus4D;

    if (PCSrcE) begin
      // Flush beats stall; any response landing this cycle is dropped.
      vld_n      = 1'b0;
      skid_vld_n = 1'b0;
      pc_n       = target;
      unique case (state)
        S_IDLE:  state_n = S_REQ;
        S_REQ:   state_n = req_fire ? S_DRAIN : S_REQ;
        S_WAIT:  state_n = ImemRspValid ? S_REQ : S_DRAIN;
        S_DRAIN: state_n = ImemRspValid ? S_REQ : S_DRAIN;
        default: state_n = S_REQ;
      endcase
    end else begin
      if (InstrValidD && !StallD) vld_n = 1'b0;

      if (skid_vld && out_free) begin
        vld_n      = 1'b1;
        instr_n    = skid_instr;
        pcd_n      = skid_pc;
        pc4_n      = skid_pc + FOUR;
        skid_vld_n = 1'b0;
      end

      unique case (state)
        S_IDLE: state_n = S_REQ;
        S_REQ:  if (req_fire) state_n = S_WAIT;
        S_WAIT: begin
          // The skid is always empty here: requests are only issued with an empty skid.
          if (ImemRspValid) begin
            if (out_free) begin
              vld_n   = 1'b1;
              instr_n = ImemRspData;
              pcd_n   = pc;
              pc4_n   = pc + FOUR;
            end else begin
              skid_vld_n   = 1'b1;
              skid_instr_n = ImemRspData;
              skid_pc_n    = pc;
            end
            pc_n    = pc + FOUR;
            state_n = S_REQ;
          end
        end
        S_DRAIN: if (ImemRspValid) state_n = S_REQ;
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      skid_vld    <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      InstrValidD <= 1'b0;
      InstrD      <= '0;
      PCD         <= '0;
      PCPlus4D    <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      skid_vld    <= skid_vld_n;
      skid_instr  <= skid_instr_n;
      skid_pc     <= skid_pc_n;
      InstrValidD <= vld_n;
      InstrD      <= instr_n;
      PCD         <= pcd_n;
      PCPlus4D    <= pc4_n;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a program-order reference model predicts the
// instruction stream seen by decode; a second instance checks PC wrap from the top of memory.
module tb_fetch_sequencer;
  localparam logic [63:0] RPC = 64'h1000;
  localparam logic [63:0] WPC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        PCSrcE = 1'b0, StallD = 1'b0;
  logic [63:0] PCTargetE = '0;
  logic        ImemReqValid, ImemReqReady = 1'b1, ImemRspValid = 1'b0;
  logic [63:0] ImemReqAddr;
  logic [31:0] ImemRspData = '0;
  logic        InstrValidD;
  logic [31:0] InstrD;
  logic [63:0] PCD, PCPlus4D;

  logic        w_req_valid, w_rsp_valid = 1'b0, w_ivld;
  logic [63:0] w_req_addr, w_pcd, w_pc4;
  logic [31:0] w_rsp_data = '0, w_instr;

  fetch_sequencer #(.XLEN(64), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .ImemReqValid(ImemReqValid), .ImemReqAddr(ImemReqAddr), .ImemReqReady(ImemReqReady),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .InstrValidD(InstrValidD), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  fetch_sequencer #(.XLEN(64), .RESET_PC(WPC)) u_wrap (
    .clk(clk), .rst(rst), .PCSrcE(1'b0), .PCTargetE(64'h0), .StallD(1'b0),
    .ImemReqValid(w_req_valid), .ImemReqAddr(w_req_addr), .ImemReqReady(1'b1),
    .ImemRspValid(w_rsp_valid), .ImemRspData(w_rsp_data),
    .InstrValidD(w_ivld), .InstrD(w_instr), .PCD(w_pcd), .PCPlus4D(w_pc4)
  );

  int tests = 0, fails = 0;
  int rdy_pct = 100, lat_max = 0;
  int cyc = 0, delivered = 0;

  typedef struct {logic [31:0] data; int due;} rsp_t;
  rsp_t        rspq[$];
  logic [63:0] expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // Expected program order restarts at the (aligned) target of every redirect.
  task automatic refill(input logic [63:0] base);
    expq.delete();
    for (int i = 0; i < 256; i++) expq.push_back(base + 64'(4 * i));
  endtask

  // Memory model: accepts a request, answers 1..lat_max+1 cycles later, in order.
  initial begin
    logic hs, rf;
    logic [63:0] a;
    rsp_t r;
    forever begin
      @(negedge clk);
      hs = ImemReqValid && ImemReqReady && !rst;
      rf = ImemRspValid;
      a  = ImemReqAddr;
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        rspq.delete();
        ImemRspValid = 1'b0;
        ImemReqReady = 1'b1;
      end else begin
        if (rf && rspq.size() != 0) void'(rspq.pop_front());
        if (hs) begin
          r.data = imem(a);
          r.due  = cyc + int'($urandom_range(0, lat_max));
          rspq.push_back(r);
        end
        ImemRspValid = 1'b0;
        ImemRspData  = $urandom;
        if (rspq.size() != 0) begin
          if (rspq[0].due <= cyc) begin
            ImemRspValid = 1'b1;
            ImemRspData  = rspq[0].data;
          end
        end
        ImemReqReady = int'($urandom_range(0, 99)) < rdy_pct;
      end
    end
  end

  // Monitor: checks decode-visible instructions and the request address stream.
  initial begin
    logic [63:0] req_exp, prev_addr, e;
    logic        prev_pend;
    req_exp   = RPC;
    prev_pend = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_exp   = RPC;
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          chk("held_req_valid", {63'h0, ImemReqValid}, 64'h1);
          chk("held_req_addr", ImemReqAddr, prev_addr);
        end
        if (InstrValidD && !StallD && !PCSrcE) begin
          if (expq.size() == 0) begin
            chk("exp_queue_empty", PCD, 64'hX);
          end else begin
            e = expq.pop_front();
            chk("pcd", PCD, e);
            chk("instrd", {32'h0, InstrD}, {32'h0, imem(e)});
            chk("pcplus4d", PCPlus4D, e + 64'd4);
            delivered++;
          end
        end
        if (PCSrcE) begin
          req_exp = PCTargetE & ~64'h3;
        end else if (ImemReqValid && ImemReqReady) begin
          chk("req_addr", ImemReqAddr, req_exp);
          req_exp = req_exp + 64'd4;
        end
        prev_pend = ImemReqValid && !ImemReqReady && !PCSrcE;
        prev_addr = ImemReqAddr;
      end
    end
  end

  // Wrap instance: ready always, one-cycle response, no stall or redirect.
  initial begin
    logic hs;
    logic [63:0] a;
    forever begin
      @(negedge clk);
      hs = w_req_valid && !rst;
      a  = w_req_addr;
      @(posedge clk); #1;
      w_rsp_valid = hs;
      w_rsp_data  = hs ? imem(a) : 32'h0;
    end
  end

  initial begin
    int nreq, ndel;
    nreq = 0;
    ndel = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (w_req_valid) begin
          if (nreq == 0) chk("wrap_req0", w_req_addr, WPC);
          if (nreq == 1) chk("wrap_req1", w_req_addr, 64'h0);
          nreq++;
        end
        if (w_ivld && ndel == 0) begin
          chk("wrap_pcd", w_pcd, WPC);
          chk("wrap_pc4", w_pc4, 64'h0);
          chk("wrap_instr", {32'h0, w_instr}, {32'h0, imem(WPC)});
          ndel++;
        end
      end
    end
  end

  task automatic phase(input int n, input int rp, input int lm, input int sp, input int dp);
    logic [63:0] tgt;
    rdy_pct = rp;
    lat_max = lm;
    repeat (n) begin
      @(posedge clk); #1;
      StallD = int'($urandom_range(0, 99)) < sp;
      if (int'($urandom_range(0, 99)) < dp) begin
        tgt = 64'($urandom_range(0, 32'hFFFF));
        if ($urandom_range(0, 7) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFE0 | (tgt & 64'h1F);
        PCSrcE    = 1'b1;
        PCTargetE = tgt;
        refill(tgt & ~64'h3);
      end else begin
        PCSrcE = 1'b0;
      end
    end
    @(posedge clk); #1;
    PCSrcE = 1'b0;
    StallD = 1'b0;
  endtask

  initial begin
    refill(RPC);
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_valid", {63'h0, ImemReqValid}, 64'h0);
      chk("rst_req_addr", ImemReqAddr, RPC);
      chk("rst_instr_valid", {63'h0, InstrValidD}, 64'h0);
      chk("rst_instr", {32'h0, InstrD}, 64'h0);
      chk("rst_pcd", PCD, 64'h0);
      chk("rst_pcplus4d", PCPlus4D, 64'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_valid", {63'h0, ImemReqValid}, 64'h0);
    @(negedge clk);
    chk("first_req_valid", {63'h0, ImemReqValid}, 64'h1);
    chk("first_req_addr", ImemReqAddr, RPC);

    phase(30, 100, 0, 0, 0);
    phase(400, 100, 0, 40, 0);
    phase(1500, 70, 2, 30, 5);
    phase(400, 20, 1, 20, 8);
    phase(1500, 60, 2, 50, 10);
    phase(60, 100, 0, 0, 0);

    chk("progress", {63'h0, delivered > 300}, 64'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
